// File: rtl/mcu_pkg.sv
// Shared definitions for the multi-cycle CPU datapath: the multiply
// sequencer state encoding, the ALU-compatible flag layout and a helper
// that derives the MUL flags from a result word.
package mcu_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PP0  = 3'd1,
        PP1  = 3'd2,
        PP2  = 3'd3,
        DONE = 3'd4
    } mul_state_t;

    // Flag bit positions inside the 4-bit {N,Z,C,V} vector, shared with the ALU.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Flags of an all-zero result: only Z set.
    localparam logic [3:0] FLAGS_RESET = 4'b0100;

    // N/Z follow the result; MUL never reports carry or overflow.
    function automatic logic [3:0] mul_flags(input logic [31:0] res);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = res[31];
        f[FLAG_Z] = (res == 32'd0);
        f[FLAG_C] = 1'b0;
        f[FLAG_V] = 1'b0;
        return f;
    endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Request/response bundle between the CPU control FSM (master) and the
// multiply sequencer (slave).
interface mul_seq_ctrl_if;

    logic        start;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [3:0]  flags;

    modport master (
        output start, flush, a, b,
        input  busy, done, result, flags
    );

    modport slave (
        input  start, flush, a, b,
        output busy, done, result, flags
    );

endinterface

// File: rtl/mul16_core.sv
// 16x16 -> 32 unsigned multiplier with MUL_LAT register stages.
// Stand-in for the vendor multiplier IP; no reset because the sequencer
// ignores whatever is in flight until its own operands have propagated.
module mul16_core #(
    parameter int MUL_LAT = 0
) (
    input  logic        clk,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic [31:0] prod
);

    logic [31:0] raw_s;

    assign raw_s = {16'd0, op_a} * {16'd0, op_b};

    generate
        if (MUL_LAT == 0) begin : g_comb
            assign prod = raw_s;
        end else begin : g_pipe
            logic [31:0] pipe_r [MUL_LAT];

            // Delay line carrying the product through MUL_LAT stages.
            always_ff @(posedge clk) begin
                pipe_r[0] <= raw_s;
                for (int i = 1; i < MUL_LAT; i++) begin
                    pipe_r[i] <= pipe_r[i-1];
                end
            end

            assign prod = pipe_r[MUL_LAT-1];
        end
    endgenerate

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle 32x32 multiply (low 32 bits) built from three 16x16 partial
// products issued on one shared core: a_lo*b_lo, a_lo*b_hi, a_hi*b_lo.
// a_hi*b_hi only contributes above bit 31 and is never issued.
module mul_seq_ctrl
    import mcu_pkg::*;
#(
    parameter int MUL_LAT = 0
) (
    input  logic         clk,
    input  logic         reset,
    mul_seq_ctrl_if.slave bus
);

    localparam int              CNT_W    = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT);

    mul_state_t       state_r;
    mul_state_t       next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      a_r;
    logic [31:0]      b_r;
    logic [31:0]      acc_r;
    logic [31:0]      result_r;
    logic [3:0]       flags_r;
    logic             busy_r;
    logic             done_r;

    logic             accept_s;
    logic             in_pp_s;
    logic             last_s;
    logic             busy_nxt_s;
    logic             done_nxt_s;
    logic [15:0]      op_a_s;
    logic [15:0]      op_b_s;
    logic [31:0]      prod_s;
    logic [31:0]      addend_s;
    logic [31:0]      acc_sum_s;

    mul16_core #(
        .MUL_LAT (MUL_LAT)
    ) u_core (
        .clk  (clk),
        .op_a (op_a_s),
        .op_b (op_b_s),
        .prod (prod_s)
    );

    // Accept only from IDLE/DONE; flush always wins; PP-state starts are dropped.
    always_comb begin
        accept_s = 1'b0;
        if (bus.start && !bus.flush && (state_r == IDLE || state_r == DONE)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Phase decode: which PP state we are in and whether its product is ready.
    always_comb begin
        in_pp_s = (state_r == PP0) || (state_r == PP1) || (state_r == PP2);
        last_s  = in_pp_s && (cnt_r == CNT_LAST);
    end

    // Operand mux: operands are held for the whole PP state so the core output
    // on the last cycle belongs to this state's operands.
    always_comb begin
        case (state_r)
            PP1:     begin op_a_s = a_r[15:0];  op_b_s = b_r[31:16]; end
            PP2:     begin op_a_s = a_r[31:16]; op_b_s = b_r[15:0];  end
            default: begin op_a_s = a_r[15:0];  op_b_s = b_r[15:0];  end
        endcase
    end

    // Cross products land at bit 16; their upper halves fall off the 32-bit word.
    always_comb begin
        case (state_r)
            PP0:      addend_s = prod_s;
            PP1, PP2: addend_s = {prod_s[15:0], 16'h0000};
            default:  addend_s = 32'd0;
        endcase
        acc_sum_s = acc_r + addend_s;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: each PP state advances on its last cycle; DONE lasts one cycle.
    always_comb begin
        next_state_s = state_r;
        if (bus.flush) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    next_state_s = accept_s ? PP0 : IDLE;
                PP0:     next_state_s = last_s ? PP1 : PP0;
                PP1:     next_state_s = last_s ? PP2 : PP1;
                PP2:     next_state_s = last_s ? DONE : PP2;
                DONE:    next_state_s = accept_s ? PP0 : IDLE;
                default: next_state_s = IDLE;
            endcase
        end
    end

    // Output decode from the next state so busy/done can be registered.
    always_comb begin
        case (next_state_s)
            PP0, PP1, PP2: begin busy_nxt_s = 1'b1; done_nxt_s = 1'b0; end
            DONE:          begin busy_nxt_s = 1'b0; done_nxt_s = 1'b1; end
            default:       begin busy_nxt_s = 1'b0; done_nxt_s = 1'b0; end
        endcase
    end

    // Per-state cycle counter covering the core latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (bus.flush || !in_pp_s || last_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Operand capture on accept; accumulator cleared on accept, summed on each PP's last cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r   <= 32'd0;
            b_r   <= 32'd0;
            acc_r <= 32'd0;
        end else if (accept_s) begin
            a_r   <= bus.a;
            b_r   <= bus.b;
            acc_r <= 32'd0;
        end else if (last_s && !bus.flush) begin
            acc_r <= acc_sum_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    // Output registers: result/flags only move on entry to DONE, so a flush keeps the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= 32'd0;
            flags_r  <= FLAGS_RESET;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
            if (next_state_s == DONE) begin
                result_r <= acc_sum_s;
                flags_r  <= mul_flags(acc_sum_s);
            end else begin
                result_r <= result_r;
                flags_r  <= flags_r;
            end
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;
    assign bus.flags  = flags_r;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: the same vector set is applied to a
// MUL_LAT=0 and a MUL_LAT=2 instance in turn.
module tb_mul_seq_ctrl;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mul_seq_ctrl_if if0 ();
    mul_seq_ctrl_if if1 ();

    mul_seq_ctrl #(.MUL_LAT(0)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
    mul_seq_ctrl #(.MUL_LAT(2)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

    logic        sel;
    logic        start_v;
    logic        flush_v;
    logic [31:0] a_v;
    logic [31:0] b_v;

    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [3:0]  flags_o;

    assign if0.start = (sel == 1'b0) ? start_v : 1'b0;
    assign if1.start = (sel == 1'b1) ? start_v : 1'b0;
    assign if0.flush = (sel == 1'b0) ? flush_v : 1'b0;
    assign if1.flush = (sel == 1'b1) ? flush_v : 1'b0;
    assign if0.a = a_v;
    assign if0.b = b_v;
    assign if1.a = a_v;
    assign if1.b = b_v;

    assign busy_o   = sel ? if1.busy   : if0.busy;
    assign done_o   = sel ? if1.done   : if0.done;
    assign result_o = sel ? if1.result : if0.result;
    assign flags_o  = sel ? if1.flags  : if0.flags;

    int n_tests = 0;
    int n_fail  = 0;
    int cur_lat = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s (MUL_LAT=%0d): got 0x%08h, expected 0x%08h", tag, cur_lat, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for done; n enters as edges already elapsed since the accept edge (inclusive).
    task automatic wait_done(inout int n);
        while (!done_o && n < 64) begin
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic [3:0] exp_flags, input int l);
        int n;
        start_v = 1'b1; a_v = a; b_v = b;
        tick();
        start_v = 1'b0;
        n = 1;
        check({tag, "_busy"}, 32'(busy_o), 32'd1);
        wait_done(n);
        check({tag, "_lat"}, 32'(n), 32'(3 * l + 1));
        check({tag, "_done"}, 32'(done_o), 32'd1);
        check({tag, "_busy_in_done"}, 32'(busy_o), 32'd0);
        check({tag, "_result"}, result_o, exp_res);
        check({tag, "_flags"}, 32'(flags_o), 32'(exp_flags));
        tick();
        check({tag, "_done_pulse"}, 32'(done_o), 32'd0);
    endtask

    task automatic run_all(input logic s, input int lat);
        int l;
        int n;
        int seen;
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [31:0] vr [3];
        l = lat + 1;
        sel = s;
        cur_lat = lat;
        start_v = 1'b0; flush_v = 1'b0; a_v = 32'd0; b_v = 32'd0;

        reset = 1'b1;
        tick();
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_flags", 32'(flags_o), 32'h4);
        reset = 1'b0;
        tick();

        run_op("basic", 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 4'b0000, l);
        run_op("allones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0000, l);
        run_op("zero", 32'h8000_0000, 32'h0000_0002, 32'h0000_0000, 4'b0100, l);
        run_op("neg", 32'h0001_0000, 32'h0000_8000, 32'h8000_0000, 4'b1000, l);

        // start held high: every DONE cycle accepts the next vector
        va[0] = 32'h0000_0003; vb[0] = 32'h0000_0005; vr[0] = 32'h0000_000F;
        va[1] = 32'h0001_0000; vb[1] = 32'h0001_0000; vr[1] = 32'h0000_0000;
        va[2] = 32'h0000_0007; vb[2] = 32'hFFFF_FFFF; vr[2] = 32'hFFFF_FFF9;
        start_v = 1'b1; a_v = va[0]; b_v = vb[0];
        tick();
        for (int k = 0; k < 3; k++) begin
            n = 1;
            wait_done(n);
            check($sformatf("b2b%0d_lat", k), 32'(n), 32'(3 * l + 1));
            check($sformatf("b2b%0d_result", k), result_o, vr[k]);
            if (k < 2) begin
                a_v = va[k+1]; b_v = vb[k+1];
            end else begin
                start_v = 1'b0;
            end
            tick();
            check($sformatf("b2b%0d_busy_after", k), 32'(busy_o), (k < 2) ? 32'd1 : 32'd0);
        end

        // start pulsed in PP1 with other operands is ignored
        start_v = 1'b1; a_v = 32'h0001_0003; b_v = 32'h0002_0005;
        tick();
        start_v = 1'b0;
        repeat (l) tick();
        start_v = 1'b1; a_v = 32'hFFFF_FFFF; b_v = 32'hFFFF_FFFF;
        tick();
        start_v = 1'b0;
        n = l + 2;
        wait_done(n);
        check("ign_lat", 32'(n), 32'(3 * l + 1));
        check("ign_result", result_o, 32'h000B_000F);
        tick();

        // flush wins over start in IDLE
        start_v = 1'b1; flush_v = 1'b1;
        tick();
        start_v = 1'b0; flush_v = 1'b0;
        check("flush_vs_start_busy", 32'(busy_o), 32'd0);

        // flush in PP1: abort, no done, result kept
        start_v = 1'b1; a_v = 32'hFFFF_FFFF; b_v = 32'hFFFF_FFFF;
        tick();
        start_v = 1'b0;
        repeat (l) tick();
        flush_v = 1'b1;
        tick();
        flush_v = 1'b0;
        check("flush_busy", 32'(busy_o), 32'd0);
        seen = 0;
        repeat (3 * l + 2) begin
            if (done_o) seen = 1;
            tick();
        end
        check("flush_no_done", 32'(seen), 32'd0);
        check("flush_result", result_o, 32'h000B_000F);
        check("flush_flags", 32'(flags_o), 32'h0);

        // async reset in PP2
        start_v = 1'b1; a_v = 32'h0000_0003; b_v = 32'h0000_0005;
        tick();
        start_v = 1'b0;
        repeat (2 * l) tick();
        check("pp2_busy", 32'(busy_o), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_done", 32'(done_o), 32'd0);
        check("arst_result", result_o, 32'd0);
        check("arst_flags", 32'(flags_o), 32'h4);
        #1 reset = 1'b0;
        tick();
        check("arst_idle_busy", 32'(busy_o), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        sel = 1'b0;
        start_v = 1'b0; flush_v = 1'b0; a_v = 32'd0; b_v = 32'd0;
        run_all(1'b0, 0);
        run_all(1'b1, 2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
